hyperbus_arbiter: RTL and testbench

HYPERBUS_ARBITER -- requirements
Module: hyperbus_arbiter

---
 rtl/hyperbus_arbiter.sv | 147 ++++++++++++++
 tb/tb_hyperbus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_arbiter.sv
// Two-port HyperBus arbiter: alternating grant, one-cycle turnaround, per-port response routing.
// Optional BUSY timeout with per-port release mask: define HYPERBUS_ARB_TIMEOUT_EN.
module hyperbus_arbiter #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         hbus_clk,
  input  logic                         hbus_rst,
  input  logic [1:0]                   req_rrq,
  input  logic [1:0]                   req_wrq,
  input  logic [2*HBUS_ADDR_WIDTH-1:0] req_adr,
  input  logic [2*HBUS_DATA_WIDTH-1:0] req_dat,
  input  logic [2*(HBUS_DATA_WIDTH/8)-1:0] req_mask,
  output logic [1:0]                   req_ready,
  output logic [1:0]                   req_valid,
  output logic [HBUS_DATA_WIDTH-1:0]   rd_dat,
  output logic [1:0]                   grant,
  output logic [1:0]                   err_timeout,
  output logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_o,
  output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
  output logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_o,
  output logic                         hbus_rrq,
  output logic                         hbus_wrq,
  input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
  input  logic                         hbus_ready,
  input  logic                         hbus_valid
);

  // state | meaning
  // IDLE  | no owner, arbitrate among eligible requesters
  // BUSY  | granted port drives the downstream bus
  // TURN  | one-cycle bus turnaround after release or timeout
  localparam int AW = HBUS_ADDR_WIDTH;
  localparam int DW = HBUS_DATA_WIDTH;
  localparam int MW = HBUS_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;

  logic [1:0] state;
  logic [1:0] grant_q;
  logic       op_rd;
  logic       last;

  logic       busy;
  logic       g;
  logic [1:0] req_any;
  logic [1:0] req_elig;
  logic       win;
  logic       op_held;
  logic       timeout_hit;

  assign busy    = (state == ST_BUSY);
  assign g       = grant_q[1];
  assign req_any = req_rrq | req_wrq;
  assign op_held = op_rd ? req_rrq[g] : req_wrq[g];
  // Prefer the port that did not own the bus last time.
  assign win     = req_elig[~last] ? ~last : last;

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt;
  logic [1:0]    rel_mask;

  assign req_elig    = req_any & ~rel_mask;
  assign timeout_hit = busy && op_held && (to_cnt == TO_LAST);
  assign err_timeout = timeout_hit ? grant_q : 2'b00;

  // A timed-out port stays masked until it has dropped both request bits.
  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      to_cnt   <= '0;
      rel_mask <= 2'b00;
    end else begin
      if (busy) to_cnt <= to_cnt + 1'b1;
      else      to_cnt <= '0;
      rel_mask <= (rel_mask & req_any) | (timeout_hit ? grant_q : 2'b00);
    end
  end
`else
  assign req_elig    = req_any;
  assign timeout_hit = 1'b0;
  assign err_timeout = 2'b00;
`endif

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      state   <= ST_IDLE;
      grant_q <= 2'b00;
      op_rd   <= 1'b0;
      last    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          grant_q <= 2'b00;
          if (|req_elig) begin
            grant_q <= win ? 2'b10 : 2'b01;
            op_rd   <= req_rrq[win];
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!op_held || timeout_hit) begin
            state   <= ST_TURN;
            grant_q <= 2'b00;
            last    <= g;
          end
        end
        ST_TURN: begin
          grant_q <= 2'b00;
          state   <= ST_IDLE;
        end
        default: begin
          grant_q <= 2'b00;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign rd_dat = hbus_dat_i;

  always_comb begin
    hbus_adr_o  = '0;
    hbus_dat_o  = '0;
    hbus_mask_o = '0;
    hbus_rrq    = 1'b0;
    hbus_wrq    = 1'b0;
    req_ready   = 2'b00;
    req_valid   = 2'b00;
    if (busy) begin
      hbus_adr_o  = g ? req_adr[2*AW-1:AW]   : req_adr[AW-1:0];
      hbus_dat_o  = g ? req_dat[2*DW-1:DW]   : req_dat[DW-1:0];
      hbus_mask_o = g ? req_mask[2*MW-1:MW]  : req_mask[MW-1:0];
      hbus_rrq    = op_rd  && req_rrq[g];
      hbus_wrq    = !op_rd && req_wrq[g];
      req_ready   = grant_q & {2{hbus_ready}};
      req_valid   = grant_q & {2{hbus_valid}};
    end
  end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Randomized bench for hyperbus_arbiter against a transaction-level ownership model.
// Follows HYPERBUS_ARB_TIMEOUT_EN when defined (DUT built with TIMEOUT_CYCLES=8).
module tb_hyperbus_arbiter;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int MW = DW / 8;
  localparam int TO = 8;
  localparam int N_CYCLES = 3000;

  logic              hbus_clk = 1'b0;
  logic              hbus_rst = 1'b1;
  logic [1:0]        req_rrq = '0, req_wrq = '0;
  logic [2*AW-1:0]   req_adr = '0;
  logic [2*DW-1:0]   req_dat = '0;
  logic [2*MW-1:0]   req_mask = '0;
  logic [1:0]        req_ready, req_valid, grant, err_timeout;
  logic [DW-1:0]     rd_dat, hbus_dat_o;
  logic [AW-1:0]     hbus_adr_o;
  logic [MW-1:0]     hbus_mask_o;
  logic              hbus_rrq, hbus_wrq;
  logic [DW-1:0]     hbus_dat_i = '0;
  logic              hbus_ready = 1'b0, hbus_valid = 1'b0;

  always #5 hbus_clk = ~hbus_clk;

  hyperbus_arbiter #(.HBUS_ADDR_WIDTH(AW), .HBUS_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst),
    .req_rrq(req_rrq), .req_wrq(req_wrq), .req_adr(req_adr), .req_dat(req_dat), .req_mask(req_mask),
    .req_ready(req_ready), .req_valid(req_valid), .rd_dat(rd_dat), .grant(grant),
    .err_timeout(err_timeout), .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o),
    .hbus_mask_o(hbus_mask_o), .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq),
    .hbus_dat_i(hbus_dat_i), .hbus_ready(hbus_ready), .hbus_valid(hbus_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, what it asked for, and who is locked out.
  int         owner;      // -1 when nobody owns the bus
  int         last;
  int         bcnt;
  bit         rd_op;
  bit         in_turn;
  logic [1:0] blocked;

  // Per-port stimulus masters.
  bit act [2];
  int kind [2];   // 0 read, 1 write, 2 both
  int serve [2];
  int gap [2];
  bit extra [2];

  task automatic model_reset();
    owner = -1; last = 1; bcnt = 0; rd_op = 0; in_turn = 0; blocked = 2'b00;
  endtask

  function automatic bit owner_holds();
    if (owner < 0) return 1'b0;
    return rd_op ? req_rrq[owner] : req_wrq[owner];
  endfunction

  task automatic model_step();
    logic [1:0] cand;
    logic [1:0] set_blk;
    int w;
    cand = (req_rrq | req_wrq) & ~blocked;
    set_blk = 2'b00;
    if (in_turn) begin
      in_turn = 0;
    end else if (owner < 0) begin
      if (cand != 2'b00) begin
        w = cand[1-last] ? 1 - last : last;
        owner = w; rd_op = req_rrq[w]; bcnt = 0;
      end
    end else begin
      if (!owner_holds()) begin
        last = owner; owner = -1; in_turn = 1;
      end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
      else if (bcnt == TO - 1) begin
        set_blk[owner] = 1'b1;
        last = owner; owner = -1; in_turn = 1;
      end
`endif
      else bcnt++;
    end
    for (int n = 0; n < 2; n++)
      if (!req_rrq[n] && !req_wrq[n]) blocked[n] = 1'b0;
    blocked = blocked | set_blk;
  endtask

  task automatic drive_inputs();
    for (int n = 0; n < 2; n++) begin
      if (act[n]) begin
        if (owner == n) begin
          if (serve[n] == 0) begin act[n] = 0; gap[n] = $urandom_range(0, 2); end
          else serve[n]--;
        end else if (blocked[n] && $urandom_range(0, 2) == 0) begin
          act[n] = 0; gap[n] = $urandom_range(0, 2);
        end
      end else if (gap[n] > 0) begin
        gap[n]--;
      end else if ($urandom_range(0, 1) == 1) begin
        act[n] = 1;
        kind[n] = $urandom_range(0, 2);
        serve[n] = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 14) : $urandom_range(0, 4);
      end
      // Opposite op bit raised only while already owning the bus.
      extra[n] = act[n] && (owner == n) && ($urandom_range(0, 3) == 0);
      req_rrq[n] = act[n] && (kind[n] != 1 || extra[n]);
      req_wrq[n] = act[n] && (kind[n] != 0 || extra[n]);
    end
    req_adr    = {$urandom, $urandom};
    req_dat    = $urandom;
    req_mask   = 4'($urandom);
    hbus_dat_i = 16'($urandom);
    hbus_ready = 1'($urandom);
    hbus_valid = 1'($urandom);
  endtask

  task automatic check_outputs();
    logic [1:0]    e_grant, e_rdy, e_vld, e_err;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [MW-1:0] e_mask;
    bit            e_rrq, e_wrq;
    e_grant = 2'b00; e_rdy = 2'b00; e_vld = 2'b00; e_err = 2'b00;
    e_adr = '0; e_dat = '0; e_mask = '0; e_rrq = 0; e_wrq = 0;
    if (owner >= 0) begin
      e_grant = 2'b01 << owner;
      e_adr   = req_adr[owner*AW +: AW];
      e_dat   = req_dat[owner*DW +: DW];
      e_mask  = req_mask[owner*MW +: MW];
      e_rrq   = rd_op && req_rrq[owner];
      e_wrq   = !rd_op && req_wrq[owner];
      e_rdy   = hbus_ready ? e_grant : 2'b00;
      e_vld   = hbus_valid ? e_grant : 2'b00;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
      if (owner_holds() && bcnt == TO - 1) e_err = e_grant;
`endif
    end
    check("grant",       grant,       e_grant);
    check("hbus_rrq",    hbus_rrq,    e_rrq);
    check("hbus_wrq",    hbus_wrq,    e_wrq);
    check("hbus_adr_o",  hbus_adr_o,  e_adr);
    check("hbus_dat_o",  hbus_dat_o,  e_dat);
    check("hbus_mask_o", hbus_mask_o, e_mask);
    check("req_ready",   req_ready,   e_rdy);
    check("req_valid",   req_valid,   e_vld);
    check("err_timeout", err_timeout, e_err);
    check("rd_dat",      rd_dat,      hbus_dat_i);
  endtask

  initial begin
    bit rst_done = 0;
    model_reset();
    for (int n = 0; n < 2; n++) begin act[n] = 0; gap[n] = 0; kind[n] = 0; serve[n] = 0; extra[n] = 0; end

    // Reset with requests and responses active: everything must stay quiet.
    req_rrq = 2'b11; req_wrq = 2'b01; hbus_ready = 1'b1; hbus_valid = 1'b1; hbus_dat_i = 16'hbeef;
    repeat (3) begin
      @(negedge hbus_clk);
      check("rst_grant", grant, 2'b00);
      check("rst_rrq",   hbus_rrq, 1'b0);
      check("rst_ready", req_ready, 2'b00);
      check("rst_err",   err_timeout, 2'b00);
    end
    req_rrq = 2'b00; req_wrq = 2'b00;

    for (int i = 0; i < N_CYCLES; i++) begin
      @(posedge hbus_clk);
      if (!hbus_rst) model_step();
      #1;
      hbus_rst = 1'b0;
      drive_inputs();
      @(negedge hbus_clk);
      check_outputs();
      // Asynchronous reset while a transaction is in flight.
      if (!rst_done && i >= 1500 && owner >= 0) begin
        #2 hbus_rst = 1'b1;
        #1;
        check("async_rst_rrq",   hbus_rrq, 1'b0);
        check("async_rst_wrq",   hbus_wrq, 1'b0);
        check("async_rst_ready", req_ready, 2'b00);
        check("async_rst_valid", req_valid, 2'b00);
        check("async_rst_grant", grant, 2'b00);
        model_reset();
        rst_done = 1;
      end
    end
    check("mid_reset_seen", 32'(rst_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
